// File: rtl/sdc_wb_regfile_if.sv
// Wishbone slave bus bundle for the SD controller register file.
interface sdc_wb_regfile_if;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/sdc_wb_regfile.sv
// Wishbone register file for the SD card controller: byte-masked registers, W1C interrupt
// clears, BD RAM write sequencer (32/BD_WIDTH beats per word) and internal command requests.
module sdc_wb_regfile #(
  parameter int          BD_WIDTH      = 16,
  parameter logic [7:0]  RESET_CLK_DIV = 8'd2,
  parameter logic [15:0] BLOCK_SIZE    = 16'd512,
  parameter bit          BUS_WIDTH_4   = 1'b1,
  parameter logic [7:0]  POWER_REG     = 8'h0F
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  sdc_wb_regfile_if.slave     wb,
  output logic                int_o,
  output logic [31:0]         argument_reg,
  output logic [15:0]         cmd_setting_reg,
  output logic                new_cmd,
  output logic                cmd_busy,
  input  logic [15:0]         status_reg,
  input  logic [31:0]         cmd_resp_1,
  output logic [7:0]          software_reset_reg,
  output logic [15:0]         time_out_reg,
  output logic [7:0]          clock_divider,
  input  logic [15:0]         normal_int_status_reg,
  input  logic [15:0]         error_int_status_reg,
  output logic [15:0]         normal_int_signal_enable_reg,
  output logic [15:0]         error_int_signal_enable_reg,
  output logic [15:0]         normal_isr_clr,
  output logic [15:0]         error_isr_clr,
  input  logic [15:0]         Bd_Status_reg,
  input  logic [7:0]          Bd_isr_reg,
  output logic [7:0]          Bd_isr_enable_reg,
  output logic [7:0]          bd_isr_clr,
  output logic                bd_rx_we,
  output logic                bd_tx_we,
  output logic [BD_WIDTH-1:0] bd_dat_o,
  input  logic                write_req_s,
  input  logic [15:0]         cmd_set_s,
  input  logic [31:0]         cmd_arg_s,
  output logic                we_ack
);

  localparam int BEATS = 32 / BD_WIDTH;

  typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        bd_tx_q;
  logic        ack_q, err_q;
  logic [31:0] dat_q;
  logic [31:0] rdata;
  logic [31:0] wmask;
  logic [31:0] bd_shift;

  logic access, is_bd, bd_wr, bd_bad, reg_acc, reg_wr, int_req;

  assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
  assign is_bd   = (wb.wb_adr_i == 8'h60) | (wb.wb_adr_i == 8'h80);
  assign bd_wr   = access & (state_q == IDLE) & wb.wb_we_i & is_bd;
  assign bd_bad  = (wb.wb_sel_i != 4'hF) |
                   ((wb.wb_adr_i == 8'h60) ? (Bd_Status_reg[7:0] == 8'd0)
                                           : (Bd_Status_reg[15:8] == 8'd0));
  assign reg_acc = access & (state_q == IDLE) & ~(wb.wb_we_i & is_bd);
  assign reg_wr  = reg_acc & wb.wb_we_i;
  // Host wins a collision; the we_ack gate stops a still-held request being taken twice.
  assign int_req = write_req_s & (state_q == IDLE) & ~access & ~we_ack;

  assign wmask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                  {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};

  assign wb.wb_ack_o = ack_q | (state_q == ACK);
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = dat_q;

  assign bd_shift = wb.wb_dat_i >> (32'(beat_q) * BD_WIDTH);
  assign bd_dat_o = (state_q == BEAT) ? bd_shift[BD_WIDTH-1:0] : '0;
  assign bd_rx_we = (state_q == BEAT) & ~bd_tx_q;
  assign bd_tx_we = (state_q == BEAT) &  bd_tx_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (bd_wr && !bd_bad) begin
        state_d = BEAT;
        beat_d  = 2'd0;
      end
      BEAT: if (beat_q == 2'(BEATS - 1)) state_d = ACK;
            else                         beat_d  = beat_q + 2'd1;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      bd_tx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (bd_wr) bd_tx_q <= (wb.wb_adr_i == 8'h80);
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (wb.wb_adr_i)
      8'h00: rdata = argument_reg;
      8'h04: rdata = {16'd0, cmd_setting_reg};
      8'h08: rdata = {16'd0, status_reg};
      8'h0C: rdata = cmd_resp_1;
      8'h1C: rdata = {30'd0, BUS_WIDTH_4, 1'b0};
      8'h20: rdata = {16'd0, BLOCK_SIZE};
      8'h24: rdata = {24'd0, POWER_REG};
      8'h28: rdata = {24'd0, software_reset_reg};
      8'h2C: rdata = {16'd0, time_out_reg};
      8'h30: rdata = {16'd0, normal_int_status_reg};
      8'h34: rdata = {16'd0, error_int_status_reg};
      8'h38: rdata = {16'd0, normal_int_signal_enable_reg};
      8'h3C: rdata = {16'd0, error_int_signal_enable_reg};
      8'h4C: rdata = {24'd0, clock_divider};
      8'h50: rdata = {16'd0, Bd_Status_reg};
      8'h54: rdata = {24'd0, Bd_isr_reg};
      8'h58: rdata = {24'd0, Bd_isr_enable_reg};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q                        <= 1'b0;
      err_q                        <= 1'b0;
      dat_q                        <= 32'd0;
      int_o                        <= 1'b0;
      argument_reg                 <= 32'd0;
      cmd_setting_reg              <= 16'd0;
      new_cmd                      <= 1'b0;
      cmd_busy                     <= 1'b0;
      software_reset_reg           <= 8'd0;
      time_out_reg                 <= 16'd0;
      clock_divider                <= RESET_CLK_DIV;
      normal_int_signal_enable_reg <= 16'd0;
      error_int_signal_enable_reg  <= 16'd0;
      normal_isr_clr               <= 16'd0;
      error_isr_clr                <= 16'd0;
      Bd_isr_enable_reg            <= 8'd0;
      bd_isr_clr                   <= 8'd0;
      we_ack                       <= 1'b0;
    end else begin
      ack_q          <= reg_acc;
      err_q          <= bd_wr & bd_bad;
      new_cmd        <= 1'b0;
      we_ack         <= 1'b0;
      normal_isr_clr <= 16'd0;
      error_isr_clr  <= 16'd0;
      bd_isr_clr     <= 8'd0;
      int_o <= (|(normal_int_status_reg & normal_int_signal_enable_reg)) |
               (|(error_int_status_reg & error_int_signal_enable_reg)) |
               (|(Bd_isr_reg & Bd_isr_enable_reg));
      if (reg_acc && !wb.wb_we_i) dat_q <= rdata;
      if (reg_wr) begin
        case (wb.wb_adr_i)
          8'h00: begin
            argument_reg <= (argument_reg & ~wmask) | (wb.wb_dat_i & wmask);
            new_cmd      <= 1'b1;
          end
          8'h04: cmd_setting_reg <= (cmd_setting_reg & ~wmask[15:0]) | (wb.wb_dat_i[15:0] & wmask[15:0]);
          8'h28: software_reset_reg <= (software_reset_reg & ~wmask[7:0]) | (wb.wb_dat_i[7:0] & wmask[7:0]);
          8'h2C: time_out_reg <= (time_out_reg & ~wmask[15:0]) | (wb.wb_dat_i[15:0] & wmask[15:0]);
          8'h30: normal_isr_clr <= wb.wb_dat_i[15:0] & wmask[15:0];
          8'h34: error_isr_clr <= wb.wb_dat_i[15:0] & wmask[15:0];
          8'h38: normal_int_signal_enable_reg <= (normal_int_signal_enable_reg & ~wmask[15:0]) |
                                                 (wb.wb_dat_i[15:0] & wmask[15:0]);
          8'h3C: error_int_signal_enable_reg <= (error_int_signal_enable_reg & ~wmask[15:0]) |
                                                (wb.wb_dat_i[15:0] & wmask[15:0]);
          8'h4C: clock_divider <= (clock_divider & ~wmask[7:0]) | (wb.wb_dat_i[7:0] & wmask[7:0]);
          8'h54: bd_isr_clr <= wb.wb_dat_i[7:0] & wmask[7:0];
          8'h58: Bd_isr_enable_reg <= (Bd_isr_enable_reg & ~wmask[7:0]) | (wb.wb_dat_i[7:0] & wmask[7:0]);
          default: ;
        endcase
      end
      if (int_req) begin
        argument_reg    <= cmd_arg_s;
        cmd_setting_reg <= cmd_set_s;
        new_cmd         <= 1'b1;
        we_ack          <= 1'b1;
      end
      // A command write in the same cycle outranks the done indication.
      if ((reg_wr && wb.wb_adr_i == 8'h04) || int_req) cmd_busy <= 1'b1;
      else if (status_reg[0])                          cmd_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdc_wb_regfile.sv
// Directed bench for sdc_wb_regfile (BD_WIDTH=16): register map, byte masks, BD writes,
// W1C clears, internal request arbitration and reset mid BD sequence.
module tb_sdc_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_o;
  logic [31:0] argument_reg;
  logic [15:0] cmd_setting_reg;
  logic        new_cmd, cmd_busy;
  logic [15:0] status_reg = '0;
  logic [31:0] cmd_resp_1 = 32'h0BADF00D;
  logic [7:0]  software_reset_reg;
  logic [15:0] time_out_reg;
  logic [7:0]  clock_divider;
  logic [15:0] normal_int_status_reg = '0, error_int_status_reg = '0;
  logic [15:0] normal_int_signal_enable_reg, error_int_signal_enable_reg;
  logic [15:0] normal_isr_clr, error_isr_clr;
  logic [15:0] Bd_Status_reg = '0;
  logic [7:0]  Bd_isr_reg = '0;
  logic [7:0]  Bd_isr_enable_reg, bd_isr_clr;
  logic        bd_rx_we, bd_tx_we;
  logic [15:0] bd_dat_o;
  logic        write_req_s = 1'b0;
  logic [15:0] cmd_set_s = '0;
  logic [31:0] cmd_arg_s = '0;
  logic        we_ack;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] rx_q[$];
  int tx_cnt;
  logic [31:0] rd;
  int lat;
  logic got_err;

  sdc_wb_regfile_if bus();

  always #5 clk = ~clk;

  sdc_wb_regfile #(.BD_WIDTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(bus), .int_o(int_o),
    .argument_reg(argument_reg), .cmd_setting_reg(cmd_setting_reg),
    .new_cmd(new_cmd), .cmd_busy(cmd_busy), .status_reg(status_reg),
    .cmd_resp_1(cmd_resp_1), .software_reset_reg(software_reset_reg),
    .time_out_reg(time_out_reg), .clock_divider(clock_divider),
    .normal_int_status_reg(normal_int_status_reg), .error_int_status_reg(error_int_status_reg),
    .normal_int_signal_enable_reg(normal_int_signal_enable_reg),
    .error_int_signal_enable_reg(error_int_signal_enable_reg),
    .normal_isr_clr(normal_isr_clr), .error_isr_clr(error_isr_clr),
    .Bd_Status_reg(Bd_Status_reg), .Bd_isr_reg(Bd_isr_reg),
    .Bd_isr_enable_reg(Bd_isr_enable_reg), .bd_isr_clr(bd_isr_clr),
    .bd_rx_we(bd_rx_we), .bd_tx_we(bd_tx_we), .bd_dat_o(bd_dat_o),
    .write_req_s(write_req_s), .cmd_set_s(cmd_set_s), .cmd_arg_s(cmd_arg_s),
    .we_ack(we_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Idles one cycle, then runs one access; returns in the cycle it terminated.
  task automatic wb_xfer(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output logic [31:0] rdat, output int cycles,
                         output logic err);
    logic done;
    @(posedge clk); #1;
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel; bus.wb_we_i = we;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    rx_q.delete(); tx_cnt = 0; cycles = 0; done = 1'b0;
    while (!done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (bd_rx_we) rx_q.push_back(bd_dat_o);
      if (bd_tx_we) tx_cnt++;
      if (bus.wb_ack_o || bus.wb_err_o) done = 1'b1;
    end
    if (!done) check("bus_timeout", 32'd0, 32'd1);
    rdat = bus.wb_dat_o;
    err  = bus.wb_err_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] d0, d1;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_clkdiv", clock_divider, 32'd2);
    check("rst_timeout", time_out_reg, 32'd0);
    check("rst_strobes", {bd_rx_we, bd_tx_we, new_cmd, we_ack, int_o, bus.wb_ack_o}, 32'd0);

    wb_xfer(8'h4C, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rd_clkdiv", rd, 32'd2);
    check("rd_lat", lat, 32'd1);
    wb_xfer(8'h20, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rd_block", rd, 32'd512);
    wb_xfer(8'h24, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rd_power", rd, 32'h0F);
    wb_xfer(8'h1C, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rd_ctrl", rd, 32'h2);
    wb_xfer(8'h44, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rd_unmapped", rd, 32'd0);
    check("rd_unmapped_ack", lat, 32'd1);

    wb_xfer(8'h2C, 32'hAAAA5555, 4'b0001, 1'b1, rd, lat, got_err);
    check("wr_timeout_lat", lat, 32'd1);
    check("wr_timeout_val", time_out_reg, 32'h0055);
    wb_xfer(8'h2C, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rd_timeout", rd, 32'h0055);

    wb_xfer(8'h00, 32'hDEADBEEF, 4'b1100, 1'b1, rd, lat, got_err);
    check("wr_arg_val", argument_reg, 32'hDEAD0000);
    check("wr_arg_newcmd", new_cmd, 32'd1);

    // BD rx write: two 16-bit beats, low half first
    Bd_Status_reg = 16'h0003;
    wb_xfer(8'h60, 32'h12345678, 4'hF, 1'b1, rd, lat, got_err);
    d0 = (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx;
    d1 = (rx_q.size() > 1) ? rx_q[1] : 16'hxxxx;
    check("bd_rx_beats", rx_q.size(), 32'd2);
    check("bd_rx_d0", d0, 32'h5678);
    check("bd_rx_d1", d1, 32'h1234);
    check("bd_rx_lat", lat, 32'd3);
    check("bd_rx_noerr", got_err, 32'd0);

    wb_xfer(8'h80, 32'h11112222, 4'hF, 1'b1, rd, lat, got_err);
    check("bd_tx_full_err", got_err, 32'd1);
    check("bd_tx_full_lat", lat, 32'd1);
    check("bd_tx_full_we", tx_cnt, 32'd0);
    Bd_Status_reg = 16'h0503;
    wb_xfer(8'h80, 32'h11112222, 4'b0011, 1'b1, rd, lat, got_err);
    check("bd_tx_sel_err", got_err, 32'd1);
    check("bd_tx_sel_we", tx_cnt, 32'd0);

    // interrupt enable, then write-1-to-clear
    normal_int_status_reg = 16'h0004;
    wb_xfer(8'h38, 32'h00000004, 4'b0011, 1'b1, rd, lat, got_err);
    @(posedge clk); #1;
    check("int_high", int_o, 32'd1);
    wb_xfer(8'h30, 32'h00000004, 4'hF, 1'b1, rd, lat, got_err);
    check("isr_clr_pulse", normal_isr_clr, 32'h0004);
    @(posedge clk); #1;
    check("isr_clr_drop", normal_isr_clr, 32'h0000);
    normal_int_status_reg = 16'h0000;
    repeat (2) @(posedge clk); #1;
    check("int_low", int_o, 32'd0);

    // internal request colliding with a host access
    @(posedge clk); #1;
    bus.wb_adr_i = 8'h20; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    write_req_s = 1'b1; cmd_set_s = 16'h1234; cmd_arg_s = 32'hCAFEBABE;
    @(posedge clk); #1;
    check("coll_host_ack", bus.wb_ack_o, 32'd1);
    check("coll_weack_wait", we_ack, 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    check("coll_weack", {we_ack, new_cmd}, 32'b11);
    check("coll_set", cmd_setting_reg, 32'h1234);
    check("coll_arg", argument_reg, 32'hCAFEBABE);
    check("coll_busy", cmd_busy, 32'd1);
    write_req_s = 1'b0;
    @(posedge clk); #1;
    check("coll_weack_once", we_ack, 32'd0);
    status_reg = 16'h0001;
    @(posedge clk); #1;
    check("busy_clear", cmd_busy, 32'd0);
    status_reg = 16'h0000;

    // reset in the middle of a BD write
    Bd_Status_reg = 16'h0003;
    @(posedge clk); #1;
    bus.wb_adr_i = 8'h60; bus.wb_dat_i = 32'hA5A5C3C3; bus.wb_sel_i = 4'hF;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("mid_bd_we", bd_rx_we, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drop_we", {bd_rx_we, bd_tx_we, bus.wb_ack_o}, 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst2_clkdiv", clock_divider, 32'd2);
    check("rst2_timeout", time_out_reg, 32'd0);
    wb_xfer(8'h24, 0, 4'hF, 1'b0, rd, lat, got_err);
    check("rst2_rd_power", rd, 32'h0F);
    check("rst2_rd_lat", lat, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdc_wb_regfile.md
Name: sdc_wb_regfile

Overview:
Parametrised Wishbone slave register file for the SD card controller; the next generation of the host-side register interface.
- Adds byte-select masking, write-1-to-clear interrupt status, a registered interrupt output and bus error responses.
- Generalises the buffer-descriptor (BD) write path to any BD RAM width (32/BD_WIDTH beats per bus word).
- Sits between the system Wishbone bus and the command/data masters and BD RAMs.

Parameters:
BD_WIDTH, 16, BD RAM data width; legal values 8, 16, 32; BEATS = 32/BD_WIDTH.
RESET_CLK_DIV, 8'd2, reset value of clock_divider.
BLOCK_SIZE, 16'd512, read-only block size register value.
BUS_WIDTH_4, 1, sets bit1 of the read-only controller register.
POWER_REG, 8'h0F, read-only power register value.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous, active-low reset
wb_adr_i  in  8  byte address
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_sel_i  in  4  byte lane enables
wb_we_i / wb_cyc_i / wb_stb_i  in  1  standard Wishbone controls
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error termination
int_o  out  1  interrupt request
argument_reg  out  32  command argument
cmd_setting_reg  out  16  command setting
new_cmd  out  1  one-cycle command start pulse
cmd_busy  out  1  command in progress
status_reg  in  16  bit0 = command done
cmd_resp_1  in  32  card response
software_reset_reg  out  8  software reset
time_out_reg  out  16  timeout
clock_divider  out  8  SD clock divider
normal_int_status_reg / error_int_status_reg  in  16  interrupt status
normal_int_signal_enable_reg / error_int_signal_enable_reg  out  16  interrupt enables
normal_isr_clr / error_isr_clr  out  16  one-cycle write-1-to-clear masks
Bd_Status_reg  in  16  [15:8] free tx BDs, [7:0] free rx BDs
Bd_isr_reg  in  8  BD interrupt status
Bd_isr_enable_reg  out  8  BD interrupt enables
bd_isr_clr  out  8  one-cycle write-1-to-clear mask
bd_rx_we / bd_tx_we  out  1  BD RAM write strobes
bd_dat_o  out  BD_WIDTH  BD RAM write data
write_req_s  in  1  internal command write request
cmd_set_s  in  16  internal command setting
cmd_arg_s  in  32  internal command argument
we_ack  out  1  internal request accepted (one-cycle pulse)

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - clock_divider=RESET_CLK_DIV; every other output and register = 0.
  - FSM returns to IDLE; any BD sequence is abandoned with no ack.
- Access detection: access = cyc&stb&~ack&~err. The master must hold the access until it is terminated.
- Register accesses:
  - Ack pulses one cycle after access is detected; read data is registered on the same edge.
  - Unmapped addresses read 0, ignore writes, and are still acked.
- Writable registers (0x00, 0x04, 0x28, 0x2C, 0x38, 0x3C, 0x4C, 0x58): byte lane k updates only when wb_sel_i[k]=1.
- Read map:
  - 0x00 argument, 0x04 command, 0x08 status, 0x0C resp1.
  - 0x1C controller, 0x20 block, 0x24 power, 0x48 capability (=0).
  - 0x30/0x34 interrupt status, 0x50 BD status, 0x54 BD isr; remaining mapped addresses read back their registers.
  - Narrow registers are zero-extended.
- Write to 0x30/0x34/0x54: the matching clr output equals wb_dat_i (lanes masked by sel) for one cycle, coincident with ack. The status inputs are not stored.
- Write to 0x00: new_cmd pulses with ack.
- Write to 0x04: sets cmd_busy. cmd_busy clears on any cycle with status_reg[0]=1 and no 0x04 write acked that cycle.
- BD writes (0x60 rx, 0x80 tx): FSM IDLE -> BEAT -> ACK -> IDLE.
  - Error: if sel!=4'hF, or the relevant free count is 0, wb_err_o pulses one cycle after detection; no strobes are issued.
  - BEAT runs BEATS cycles, b = 0..BEATS-1:
    - bd_dat_o = wb_dat_i[b*BD_WIDTH +: BD_WIDTH] (low half first);
    - the selected bd_*_we is high every BEAT cycle.
  - ACK: wb_ack_o pulses; strobes low.
  - Latency is BEATS+1 cycles from detection.
  - BD reads return 0 with a normal ack.
- Internal request:
  - Accepted only when FSM=IDLE and no access is detected that cycle; the host wins on collision.
  - On acceptance: load cmd_set_s and cmd_arg_s, set cmd_busy, and pulse new_cmd and we_ack together.
  - The requester holds write_req_s until we_ack.
- int_o is registered, one cycle after the inputs: |(normal&en) | |(error&en) | |(Bd_isr_reg&Bd_isr_enable_reg).
- ack and err are never both high; neither is asserted without cyc&stb.

Test Plan:
- Reset, then read 0x4C, 0x20, 0x24 -> 8'd2, 512, 0x0F; all strobes are 0.
- Write 0x2C with data 0xAAAA5555, sel=4'b0001 -> time_out_reg=0x0055; ack exactly one cycle after stb.
- BD_WIDTH=16, write 0x60 with 0x12345678, free rx=3 -> two bd_rx_we cycles with 0x5678 then 0x1234; ack in cycle 3.
- Write 0x80 with free tx=0 -> wb_err_o one cycle, no bd_tx_we. Repeat with sel=4'b0011 -> err.
- Write 0x30 with 0x0004 while normal status=0x0004 and enable=0x0004 -> int_o high beforehand; normal_isr_clr=0x0004 for one cycle.
- write_req_s in the same cycle as a host access -> host acked first; we_ack and new_cmd follow the next idle cycle with cmd_set_s loaded.
- Reset asserted mid BD sequence -> strobes drop immediately; FSM is IDLE after release.
